timekeeper_core: RTL

- Parametrised successor to the free-running hh:mm:ss counter.
- Adds an internal prescaler, so the block runs directly off the system clock and advances once per configurable number of cycles.
- Adds validated time load, a 12/24-hour display mode, a minute-resolution alarm and a day-wrap pulse.
- Sits between the system clock domain and the display/alarm logic.

---
 rtl/timekeeper_pkg.sv | 37 +++
 rtl/tick_prescaler.sv | 46 ++++
 rtl/timekeeper_core.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/timekeeper_pkg.sv
// Shared field widths, time limits, the time-of-day record and the load
// classification used by the timekeeper block.
package timekeeper_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX     = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX     = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX    = 5'd23;
    localparam logic [HOUR_W-1:0] HOUR12_NOON = 5'd12;

    // One time-of-day value, hours in 24h form.
    typedef struct packed {
        logic [HOUR_W-1:0] h;
        logic [MIN_W-1:0]  m;
        logic [SEC_W-1:0]  s;
    } tod_t;

    // What a load strobe does on a given edge.
    typedef enum logic [1:0] {
        LOAD_NONE,
        LOAD_ACCEPT,
        LOAD_REJECT
    } load_action_e;

    // True when every field of a candidate time lies inside its legal range.
    function automatic logic todInRange(
        input logic [HOUR_W-1:0] hh,
        input logic [MIN_W-1:0]  mm,
        input logic [SEC_W-1:0]  ss
    );
        return (hh <= HOUR_MAX) && (mm <= MIN_MAX) && (ss <= SEC_MAX);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-per-second tick. The counter only
// moves while enabled, so a paused clock resumes at the same phase; an
// accepted time load clears it so the new second starts a full period later.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000,
    parameter int PRE_W    = $clog2(TICK_DIV) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // Compared at full PRE_W width so TICK_DIV=1 yields a constant-zero limit.
    localparam logic [PRE_W-1:0] LAST_COUNT = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] preCount_q;
    logic [PRE_W-1:0] preCount_d;

    // Next count: clear wins, otherwise advance and wrap while enabled.
    always_comb begin
        preCount_d = preCount_q;
        if (clr) begin
            preCount_d = '0;
        end else if (en) begin
            if (preCount_q == LAST_COUNT) begin
                preCount_d = '0;
            end else begin
                preCount_d = preCount_q + PRE_W'(1);
            end
        end
    end

    // Counter register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preCount_q <= '0;
        end else begin
            preCount_q <= preCount_d;
        end
    end

    assign tick = en && (preCount_q == LAST_COUNT);

endmodule

// File: rtl/timekeeper_core.sv
// hh:mm:ss time-of-day counter driven straight from the system clock.
// Provides validated loading, a 12/24-hour display view, a minute-resolution
// alarm and a midnight roll pulse. All pulse outputs are registered so they
// line up with the time value they describe.
module timekeeper_core
    import timekeeper_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int PRE_W    = $clog2(TICK_DIV) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [HOUR_W-1:0] load_h,
    input  logic [MIN_W-1:0]  load_m,
    input  logic [SEC_W-1:0]  load_s,
    input  logic              mode12,
    input  logic              alarm_en,
    input  logic [HOUR_W-1:0] alarm_h,
    input  logic [MIN_W-1:0]  alarm_m,
    output logic [SEC_W-1:0]  s,
    output logic [MIN_W-1:0]  m,
    output logic [HOUR_W-1:0] h,
    output logic [HOUR_W-1:0] disp_h,
    output logic              pm,
    output logic              sec_tick,
    output logic              day_wrap,
    output logic              alarm,
    output logic              load_err
);

    tod_t         time_q;
    tod_t         time_d;
    tod_t         advTime;
    tod_t         loadTime;
    logic         advWrap;
    logic         tick;
    logic         alarmMatch;
    load_action_e loadAction;

    logic secTick_q;
    logic secTick_d;
    logic dayWrap_q;
    logic dayWrap_d;
    logic alarm_q;
    logic alarm_d;
    logic loadErr_q;
    logic loadErr_d;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .PRE_W    (PRE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (loadAction == LOAD_ACCEPT),
        .tick  (tick)
    );

    // Classify the load strobe; a rejected load leaves time and prescaler alone.
    always_comb begin
        loadTime.h = load_h;
        loadTime.m = load_m;
        loadTime.s = load_s;
        loadAction = LOAD_NONE;
        if (load) begin
            if (todInRange(load_h, load_m, load_s)) begin
                loadAction = LOAD_ACCEPT;
            end else begin
                loadAction = LOAD_REJECT;
            end
        end
    end

    // The time one second after the current one, with the midnight roll flag.
    always_comb begin
        advTime = time_q;
        advWrap = 1'b0;
        if (time_q.s == SEC_MAX) begin
            advTime.s = '0;
            if (time_q.m == MIN_MAX) begin
                advTime.m = '0;
                if (time_q.h == HOUR_MAX) begin
                    advTime.h = '0;
                    advWrap   = 1'b1;
                end else begin
                    advTime.h = time_q.h + 5'd1;
                end
            end else begin
                advTime.m = time_q.m + 6'd1;
            end
        end else begin
            advTime.s = time_q.s + 6'd1;
        end
    end

    // Alarm matches the start of the armed minute; illegal alarm fields never match.
    always_comb begin
        alarmMatch = alarm_en
                     && (alarm_h <= HOUR_MAX) && (alarm_m <= MIN_MAX)
                     && (advTime.h == alarm_h) && (advTime.m == alarm_m)
                     && (advTime.s == '0);
    end

    // Next time and pulses: an accepted load overrides a coincident tick.
    always_comb begin
        time_d    = time_q;
        secTick_d = 1'b0;
        dayWrap_d = 1'b0;
        alarm_d   = 1'b0;
        loadErr_d = (loadAction == LOAD_REJECT);
        if (loadAction == LOAD_ACCEPT) begin
            time_d = loadTime;
        end else if (tick) begin
            time_d    = advTime;
            secTick_d = 1'b1;
            dayWrap_d = advWrap;
            alarm_d   = alarmMatch;
        end
    end

    // Time and pulse registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q    <= '0;
            secTick_q <= 1'b0;
            dayWrap_q <= 1'b0;
            alarm_q   <= 1'b0;
            loadErr_q <= 1'b0;
        end else begin
            time_q    <= time_d;
            secTick_q <= secTick_d;
            dayWrap_q <= dayWrap_d;
            alarm_q   <= alarm_d;
            loadErr_q <= loadErr_d;
        end
    end

    // Display hour: midnight and noon both show as 12 in 12-hour mode.
    always_comb begin
        disp_h = time_q.h;
        pm     = 1'b0;
        if (mode12) begin
            if (time_q.h == '0) begin
                disp_h = HOUR12_NOON;
            end else if (time_q.h < HOUR12_NOON) begin
                disp_h = time_q.h;
            end else if (time_q.h == HOUR12_NOON) begin
                disp_h = HOUR12_NOON;
                pm     = 1'b1;
            end else begin
                disp_h = time_q.h - HOUR12_NOON;
                pm     = 1'b1;
            end
        end
    end

    assign s        = time_q.s;
    assign m        = time_q.m;
    assign h        = time_q.h;
    assign sec_tick = secTick_q;
    assign day_wrap = dayWrap_q;
    assign alarm    = alarm_q;
    assign load_err = loadErr_q;

endmodule
